// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
//   Serial receive front-end for the CPU's UART load path. The asynchronous RX
//   line is synchronised to clk, 8N1 frames are deserialised by a small FSM,
//   and good bytes are queued in a first-word fall-through FIFO that the UART
//   load logic pops when it reads the RX data address.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   When defined, a PARITY state follows DATA and even parity is required
//   (8E1 frames). A mismatching frame is discarded at the stop bit and the
//   sticky output parity_err is set. When undefined, frames are 8N1 and the
//   parity_err port does not exist.
//
// Parameters:
//   CLKS_PER_BIT  core-clock cycles per bit period (>= 4)
//   FIFO_DEPTH    receive FIFO entries (power of two, >= 2)
//   CNT_W         width of count, 2**CNT_W > FIFO_DEPTH
//
// Ports:
//   clk         core clock, rising edge
//   reset       asynchronous, active-high reset
//   rx          serial RX line, asynchronous, idle high
//   pop         one-cycle pulse, removes the FIFO head (ignored when empty)
//   clr_err     clears the sticky error flags
//   rd_data     FIFO head byte, 8'h00 when empty
//   rd_valid    FIFO not empty
//   full        FIFO holds FIFO_DEPTH entries
//   count       number of FIFO entries
//   frame_err   sticky: a stop bit was sampled low
//   overrun     sticky: a good frame arrived while the FIFO was full
//   parity_err  sticky: parity mismatch (UART_RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             pop,
  input  logic             clr_err,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             frame_err,
  output logic             overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Resets to the idle (high) level so that leaving reset
  // never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking '=' here would collapse the two stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM state
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              par_bad;

  logic baud_done;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // Stop-bit sample edge and the decisions taken on it.
  logic stop_sample;
  logic frame_ok;
  logic pop_eff;
  logic push;
  logic ovr_set;
  logic ferr_set;

  assign stop_sample = (state == S_STOP) && baud_done;
  assign frame_ok    = rxs && !par_bad;
  assign pop_eff     = pop && rd_valid;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push        = stop_sample && frame_ok && (!full || pop);
  assign ovr_set     = stop_sample && frame_ok && full && !pop;
  assign ferr_set    = stop_sample && !rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            baud_cnt <= '0;
            state    <= S_START;
          end
        end

        // Re-check the start bit at mid-bit; a high level there is a glitch.
        S_START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            if (!rxs) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end else begin
              state   <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        // LSB first: each new bit enters at the top and moves down.
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {rxs, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: data bits XOR parity bit must be zero.
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            par_bad  <= ^{shift, rxs};
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        // Holding here through a break gives exactly one frame_err event.
        S_WAIT_HIGH: begin
          if (rxs) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; empty entries are never visible
  // because rd_data is gated by rd_valid, and a reset term would block RAM
  // inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_valid = (count != '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set on the same edge as clr_err wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set || (frame_err && !clr_err);
      overrun   <= ovr_set  || (overrun   && !clr_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (stop_sample && par_bad) || (parity_err && !clr_err);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_buffer
//   Directed bench for uart_rx_buffer with CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
//   A table of operations (send frame, pop, clear, break, glitch, idle) is
//   applied in order and the FIFO/flag outputs are compared against
//   hand-computed values after each one. A hand-written sequence covers reset
//   asserted in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_buffer;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          pop;
  logic          clr_err;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          full;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_rx_buffer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .pop       (pop),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {OP_SEND, OP_POP, OP_CLR, OP_BREAK, OP_GLITCH, OP_IDLE} op_t;
  typedef enum logic [1:0] {ST_NONE, ST_POP, ST_CLR} strobe_t;

  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       stop;
    strobe_t    strobe;   // pulse aligned with the stop-bit sample edge
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_full;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit period; an optional strobe covers the 11th edge of the bit, which
  // is the edge on which the DUT samples the stop bit.
  task automatic send_bit(input logic v, input strobe_t s);
    rx = v;
    if (s == ST_NONE) begin
      wait_cycles(CPB);
    end else begin
      wait_cycles(10);
      if (s == ST_POP) pop = 1'b1;
      else             clr_err = 1'b1;
      wait_cycles(1);
      pop     = 1'b0;
      clr_err = 1'b0;
      wait_cycles(CPB - 11);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input strobe_t s);
    send_bit(1'b0, ST_NONE);
    for (int i = 0; i < 8; i++) send_bit(d[i], ST_NONE);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, ST_NONE);
`endif
    send_bit(stop, s);
  endtask

  function automatic vec_t mk(input op_t op, input logic [7:0] d, input logic st,
                              input strobe_t sb, input int c, input logic [7:0] h,
                              input logic f, input logic fe, input logic ov);
    vec_t v;
    v.op = op; v.data = d; v.stop = st; v.strobe = sb;
    v.exp_count = c; v.exp_head = h; v.exp_full = f; v.exp_ferr = fe; v.exp_ovr = ov;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected to finish earlier");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    pop     = 1'b0;
    clr_err = 1'b0;
    wait_cycles(3);
    check("reset count", 32'(count), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;

    //             op         data   stop  strobe   cnt head   full fe ov
    vecs.push_back(mk(OP_IDLE,   8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'hA5, 1'b1, ST_NONE, 1, 8'hA5, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h01, 1'b1, ST_NONE, 1, 8'h01, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h02, 1'b1, ST_NONE, 2, 8'h01, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h03, 1'b1, ST_NONE, 3, 8'h01, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h04, 1'b1, ST_NONE, 4, 8'h01, 1, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h05, 1'b1, ST_NONE, 4, 8'h01, 1, 0, 1));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 3, 8'h02, 0, 0, 1));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 2, 8'h03, 0, 0, 1));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 1, 8'h04, 0, 0, 1));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(OP_CLR,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h3C, 1'b0, ST_NONE, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(OP_BREAK,  8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h3C, 1'b1, ST_NONE, 1, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_GLITCH, 8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h7E, 1'b1, ST_NONE, 1, 8'h7E, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h11, 1'b1, ST_NONE, 1, 8'h11, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h22, 1'b1, ST_NONE, 2, 8'h11, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h33, 1'b1, ST_NONE, 3, 8'h11, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h44, 1'b1, ST_NONE, 4, 8'h11, 1, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h55, 1'b1, ST_POP,  4, 8'h22, 1, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 3, 8'h33, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 2, 8'h44, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 1, 8'h55, 0, 0, 0));
    vecs.push_back(mk(OP_POP,    8'h00, 1'b1, ST_NONE, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h66, 1'b1, ST_NONE, 1, 8'h66, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h77, 1'b1, ST_POP,  1, 8'h77, 0, 0, 0));
    vecs.push_back(mk(OP_SEND,   8'h99, 1'b0, ST_CLR,  1, 8'h77, 0, 1, 0));
    vecs.push_back(mk(OP_IDLE,   8'h00, 1'b1, ST_NONE, 1, 8'h77, 0, 1, 0));
    vecs.push_back(mk(OP_CLR,    8'h00, 1'b1, ST_NONE, 1, 8'h77, 0, 0, 0));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_SEND: send_byte(vecs[i].data, vecs[i].stop, vecs[i].strobe);
        OP_POP: begin
          pop = 1'b1; wait_cycles(1); pop = 1'b0;
        end
        OP_CLR: begin
          clr_err = 1'b1; wait_cycles(1); clr_err = 1'b0;
        end
        OP_BREAK: begin
          // Line stays low after a bad stop bit; the flag is cleared midway so
          // a second error event would show up.
          rx = 1'b0; wait_cycles(20);
          clr_err = 1'b1; wait_cycles(1); clr_err = 1'b0;
          wait_cycles(19);
          rx = 1'b1; wait_cycles(200);
        end
        OP_GLITCH: begin
          rx = 1'b0; wait_cycles(5);
          rx = 1'b1; wait_cycles(40);
        end
        default: begin
          rx = 1'b1; wait_cycles(100);
        end
      endcase
      @(negedge clk);
      check($sformatf("v%0d count", i),     32'(count),     32'(vecs[i].exp_count));
      check($sformatf("v%0d rd_data", i),   32'(rd_data),   32'(vecs[i].exp_head));
      check($sformatf("v%0d rd_valid", i),  32'(rd_valid),  32'(vecs[i].exp_count != 0));
      check($sformatf("v%0d full", i),      32'(full),      32'(vecs[i].exp_full));
      check($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d overrun", i),   32'(overrun),   32'(vecs[i].exp_ovr));
    end

    // Reset in the middle of a frame with one byte queued: FIFO empties and
    // the partial frame must not complete afterwards.
    rx = 1'b0;
    wait_cycles(50);
    reset = 1'b1;
    wait_cycles(1);
    check("midreset count", 32'(count), 32'd0);
    check("midreset rd_data", 32'(rd_data), 32'h00);
    wait_cycles(2);
    rx    = 1'b1;
    reset = 1'b0;
    wait_cycles(200);
    @(negedge clk);
    check("postreset count", 32'(count), 32'd0);
    check("postreset rd_valid", 32'(rd_valid), 32'd0);
    check("postreset frame_err", 32'(frame_err), 32'd0);
    send_byte(8'h5A, 1'b1, ST_NONE);
    @(negedge clk);
    check("after reset rx count", 32'(count), 32'd1);
    check("after reset rx data", 32'(rd_data), 32'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Serial receive front-end for the CPU's UART load path. Samples the asynchronous RX line on the core clock, deserialises 8N1 frames, and queues received bytes in a small FIFO. The UART load/store logic pops the FIFO when a load from the UART data address executes, and uses `rd_data` as the source of the RX read value.

Parameters:
- CLKS_PER_BIT, 868, core-clock cycles per bit period (100 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥ 2.
- CNT_W, 5, width of `count`; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial RX line, asynchronous to clk, idle high.
- pop  input  1  one-cycle pulse; removes the head entry.
- clr_err  input  1  clears `frame_err` and `overrun` (sticky flags).
- rd_data  output  8  head-of-FIFO byte, first-word fall-through.
- rd_valid  output  1  FIFO not empty.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- count  output  CNT_W  current number of entries.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a good frame arrived while the FIFO was full.

Behaviour:
- Reset (asynchronous):
  - FSM returns to IDLE; FIFO pointers, `count`, and the bit and baud counters go to 0.
  - `rd_valid`, `full`, `frame_err`, and `overrun` go to 0.
  - `rd_data` is 8'h00.
  - Synchroniser flops reset to 1.
  - Reset asserted mid-frame discards the partial frame.
- Input sync: `rx` passes through a 2-flop synchroniser; the FSM uses only the synchronised value `rxs`.
- FSM states and transitions:
  - IDLE: when `rxs` = 0, clear the baud counter and go to START.
  - START: count CLKS_PER_BIT/2 − 1 cycles, then sample `rxs`.
    - 0: clear the baud counter and go to DATA.
    - 1: glitch; return to IDLE with no flag set.
  - DATA: sample `rxs` every CLKS_PER_BIT cycles and shift it in LSB first. After the 8th sample, go to STOP (or PARITY; see Optional Feature).
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - 1, FIFO not full: push the byte and go to IDLE.
    - 1, FIFO full and no pop this cycle: drop the byte, set `overrun`, go to IDLE.
    - 0: discard the byte, set `frame_err`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then go to IDLE. A break condition produces exactly one `frame_err` event.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - `rd_data` = mem[rd_ptr] while `rd_valid` = 1, otherwise 8'h00.
  - A pushed byte is visible on `rd_data`/`rd_valid` on the cycle after the stop-bit sample edge.
  - `pop` while empty is ignored: no pointer change, no error.
  - Push and pop in the same cycle: both take effect and `count` is unchanged. This applies when full (no overrun) and when count = 1.
  - `full` = (`count` == FIFO_DEPTH); `rd_valid` = (`count` != 0).
- Sticky flags:
  - `clr_err` clears both flags.
  - If `clr_err` coincides with a new error event in the same cycle, the set wins.
- Timing: the sampling point is mid-bit ± 1 cycle, plus 2 cycles of synchroniser delay.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP; it samples one bit after CLKS_PER_BIT cycles.
  - Even parity is required: the XOR of 8 data bits plus the parity bit must be 0.
  - On mismatch, the frame is discarded at STOP and the sticky output `parity_err` (1 bit, reset 0, cleared by `clr_err`) is set.
  - A frame with both a parity error and a stop error sets both flags.
- Undefined: no PARITY state and no `parity_err` port; frames are 8N1.

Test Plan:
All cases use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
- Reset, then drive `rx` = 1 for 100 cycles → `rd_valid` = 0, `count` = 0, `rd_data` = 8'h00, both flags 0.
- Send byte 8'hA5 as 8N1 → after the stop bit, `rd_valid` = 1, `rd_data` = 8'hA5, `count` = 1. Pulse `pop` → `rd_valid` = 0, `count` = 0.
- Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no pops → `full` = 1, `count` = 4, `overrun` = 1. Pops return 01, 02, 03, 04 in order; 05 is lost. Pulse `clr_err` → `overrun` = 0.
- Send 8'h3C with the stop bit driven 0, and hold `rx` low for 40 cycles → `frame_err` = 1, `count` unchanged, no second error. Then send 8'h3C with a correct stop bit → it is received normally.
- Drive a 5-cycle low pulse on `rx` → glitch rejected: no byte, no flags, and the next valid frame 8'h7E is received.
- With the FIFO full (4 entries), assert `pop` on the same cycle as the 5th frame's stop sample → `overrun` = 0, `count` stays 4, and the 5th byte is the new tail.
